// File: rtl/ldpc_sram_1rw1r_param.sv
// Parameterised 1RW+1R SRAM model with lane write masks, an optional output
// register stage, same-address write-to-read forwarding and a post-reset zero-fill.
module ldpc_sram_1rw1r_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned WMASK_GRAN = 8,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csb0,
  input  logic                             web0,
  input  logic [DATA_WIDTH/WMASK_GRAN-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]            addr0,
  input  logic [DATA_WIDTH-1:0]            din0,
  output logic [DATA_WIDTH-1:0]            dout0,
  output logic                             dout0_valid,
  input  logic                             csb1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  output logic [DATA_WIDTH-1:0]            dout1,
  output logic                             dout1_valid,
  output logic                             collision,
  output logic                             init_busy
);
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_READY  = 1'b1;
  localparam logic [0:0] RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  if (DATA_WIDTH % WMASK_GRAN != 0) begin : g_bad_gran
    $error("DATA_WIDTH must be a multiple of WMASK_GRAN");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [DATA_WIDTH-1:0] rd0_data_q, rd0_data_d;
  logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic                  rd0_vld_q, rd0_vld_d;
  logic                  rd1_vld_q, rd1_vld_d;
  logic                  coll_q, coll_d;

  logic                  ready, wr_en, rd0_en, rd1_en, coll;
  logic [DATA_WIDTH-1:0] bit_mask, merged;

  assign ready     = (state_q == ST_READY);
  assign init_busy = (state_q == ST_INIT);
  assign wr_en     = ready && !csb0 && !web0;
  assign rd0_en    = ready && !csb0 && web0;
  assign rd1_en    = ready && !csb1;
  assign coll      = wr_en && rd1_en && (addr1 == addr0) && (|wmask0);

  always_comb begin
    bit_mask = '0;
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      bit_mask[i*WMASK_GRAN +: WMASK_GRAN] = {WMASK_GRAN{wmask0[i]}};
    end
    merged = (mem[addr0] & ~bit_mask) | (din0 & bit_mask);
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_ONE;
      if (init_addr_q == '1) state_d = ST_READY;
    end
  end

  // Read data registers only load on a read so the outputs hold the last result.
  always_comb begin
    rd0_vld_d  = rd0_en;
    rd1_vld_d  = rd1_en;
    coll_d     = coll;
    rd0_data_d = rd0_en ? mem[addr0] : rd0_data_q;
    rd1_data_d = rd1_data_q;
    if (rd1_en) rd1_data_d = (BYPASS != 0 && coll) ? merged : mem[addr1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_addr_q <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
      rd0_vld_q   <= 1'b0;
      rd1_vld_q   <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
      rd0_vld_q   <= rd0_vld_d;
      rd1_vld_q   <= rd1_vld_d;
      coll_q      <= coll_d;
    end
  end

  // Array has no reset; contents only change through the sweep or a masked write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[init_addr_q] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
          if (wmask0[i]) mem[addr0][i*WMASK_GRAN +: WMASK_GRAN] <= din0[i*WMASK_GRAN +: WMASK_GRAN];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic                  ov0_q, ov1_q, ocoll_q;

    always_comb begin
      out0_d = rd0_vld_q ? rd0_data_q : out0_q;
      out1_d = rd1_vld_q ? rd1_data_q : out1_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out0_q  <= '0;
        out1_q  <= '0;
        ov0_q   <= 1'b0;
        ov1_q   <= 1'b0;
        ocoll_q <= 1'b0;
      end else begin
        out0_q  <= out0_d;
        out1_q  <= out1_d;
        ov0_q   <= rd0_vld_q;
        ov1_q   <= rd1_vld_q;
        ocoll_q <= coll_q;
      end
    end

    assign dout0       = out0_q;
    assign dout1       = out1_q;
    assign dout0_valid = ov0_q;
    assign dout1_valid = ov1_q;
    assign collision   = ocoll_q;
  end else begin : g_no_out_reg
    assign dout0       = rd0_data_q;
    assign dout1       = rd1_data_q;
    assign dout0_valid = rd0_vld_q;
    assign dout1_valid = rd1_vld_q;
    assign collision   = coll_q;
  end

endmodule

// File: tb/tb_ldpc_sram_1rw1r_param.sv
// Bench for ldpc_sram_1rw1r_param: a default instance checked against an array
// model under random traffic, plus a wide/registered/no-bypass/no-init instance.
module tb_ldpc_sram_1rw1r_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (32b, 512 words, OUT_REG=0, BYPASS=1, INIT_ZERO=1)
  logic        rst_a, csb0_a, web0_a, csb1_a;
  logic [3:0]  wmask0_a;
  logic [8:0]  addr0_a, addr1_a;
  logic [31:0] din0_a, dout0_a, dout1_a;
  logic        v0_a, v1_a, col_a, busy_a;

  ldpc_sram_1rw1r_param dut_a (
    .clk(clk), .rst(rst_a), .csb0(csb0_a), .web0(web0_a), .wmask0(wmask0_a),
    .addr0(addr0_a), .din0(din0_a), .dout0(dout0_a), .dout0_valid(v0_a),
    .csb1(csb1_a), .addr1(addr1_a), .dout1(dout1_a), .dout1_valid(v1_a),
    .collision(col_a), .init_busy(busy_a)
  );

  // Instance B: 64b, 16-bit lanes, 16 words, registered outputs, no forwarding, no zero-fill
  logic        rst_b, csb0_b, web0_b, csb1_b;
  logic [3:0]  wmask0_b;
  logic [3:0]  addr0_b, addr1_b;
  logic [63:0] din0_b, dout0_b, dout1_b;
  logic        v0_b, v1_b, col_b, busy_b;

  ldpc_sram_1rw1r_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_GRAN(16),
    .OUT_REG(1), .BYPASS(0), .INIT_ZERO(0)
  ) dut_b (
    .clk(clk), .rst(rst_b), .csb0(csb0_b), .web0(web0_b), .wmask0(wmask0_b),
    .addr0(addr0_b), .din0(din0_b), .dout0(dout0_b), .dout0_valid(v0_b),
    .csb1(csb1_b), .addr1(addr1_b), .dout1(dout1_b), .dout1_valid(v1_b),
    .collision(col_b), .init_busy(busy_b)
  );

  // Reference model for instance A
  logic [31:0] ma [512];
  logic [31:0] exp_d0, exp_d1;
  logic        exp_v0, exp_v1, exp_col;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes32(input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | (32'hFF << (8 * i));
    return r;
  endfunction

  task automatic a_idle;
    csb0_a = 1'b1; web0_a = 1'b1; wmask0_a = 4'h0; csb1_a = 1'b1;
  endtask

  task automatic b_idle;
    csb0_b = 1'b1; web0_b = 1'b1; wmask0_b = 4'h0; csb1_b = 1'b1;
  endtask

  // Predict instance A's outputs for the current inputs, update the model, clock once.
  task automatic a_step;
    logic [31:0] bm, old0, old1;
    bm   = lanes32(wmask0_a);
    old0 = ma[addr0_a];
    old1 = ma[addr1_a];
    exp_v0 = 1'b0; exp_v1 = 1'b0; exp_col = 1'b0;
    if (!csb0_a && web0_a) begin
      exp_v0 = 1'b1; exp_d0 = old0;
    end
    if (!csb1_a) begin
      exp_v1 = 1'b1;
      exp_d1 = old1;
      if (!csb0_a && !web0_a && addr0_a == addr1_a && wmask0_a != 4'h0) begin
        exp_col = 1'b1;
        exp_d1  = (old1 & ~bm) | (din0_a & bm);
      end
    end
    if (!csb0_a && !web0_a) ma[addr0_a] = (old0 & ~bm) | (din0_a & bm);
    tick();
  endtask

  task automatic test_reset;
    rst_a = 1'b1; csb0_a = 1'b0; web0_a = 1'b1; csb1_a = 1'b0;
    tick(); tick();
    n_checks++;
    if ({dout0_a, dout1_a} !== 64'h0) begin
      n_fail++; $display("FAIL reset_dout: got %h expected %h", {dout0_a, dout1_a}, 64'h0);
    end
    n_checks++;
    if ({v0_a, v1_a, col_a, busy_a} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected %b", {v0_a, v1_a, col_a, busy_a}, 4'b0001);
    end
  endtask

  // Count init_busy cycles from the current sample while hammering both ports.
  task automatic count_init(input string name);
    int cnt, bad;
    cnt = 0; bad = 0;
    while (busy_a === 1'b1 && cnt < 1000) begin
      cnt++;
      if (v0_a || v1_a || col_a) bad++;
      csb0_a = 1'b0; web0_a = 1'($urandom_range(1)); wmask0_a = 4'hF;
      addr0_a = 9'($urandom_range(15)); din0_a = $urandom;
      csb1_a = 1'b0; addr1_a = addr0_a;
      tick();
    end
    if (v0_a || v1_a || col_a) bad++;
    a_idle();
    n_checks++;
    if (cnt != 512) begin
      n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cnt, 512);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL %s_valid_during_init: got %0d pulses expected 0", name, bad);
    end
    for (int i = 0; i < 512; i++) ma[i] = 32'h0;
  endtask

  task automatic test_init_sweep;
    rst_a = 1'b0;
    count_init("init");
  endtask

  task automatic test_init_reads;
    csb1_a = 1'b0; addr1_a = 9'd0; csb0_a = 1'b0; web0_a = 1'b1; addr0_a = 9'd511;
    a_step();
    n_checks++;
    if ({v0_a, dout0_a, v1_a, dout1_a} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL init_read_0_511: got %h expected %h", {v0_a, dout0_a, v1_a, dout1_a}, {1'b1, 32'h0, 1'b1, 32'h0});
    end
    addr1_a = 9'd511;
    a_step();
    n_checks++;
    if ({v1_a, dout1_a} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL init_read_511: got %h expected %h", {v1_a, dout1_a}, {1'b1, 32'h0});
    end
    a_idle();
  endtask

  task automatic test_mask_write;
    csb0_a = 1'b0; web0_a = 1'b0; addr0_a = 9'd5; din0_a = 32'hAABBCCDD; wmask0_a = 4'b1111;
    a_step();
    din0_a = 32'h11223344; wmask0_a = 4'b0101;
    a_step();
    n_checks++;
    if ({v0_a, dout0_a} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL write_no_dout: got %h expected %h", {v0_a, dout0_a}, {1'b0, 32'h0});
    end
    web0_a = 1'b1; wmask0_a = 4'h0; csb1_a = 1'b0; addr1_a = 9'd5;
    a_step();
    n_checks++;
    if ({v0_a, dout0_a, v1_a, dout1_a} !== {1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44}) begin
      n_fail++; $display("FAIL mask_read: got %h expected %h", {v0_a, dout0_a, v1_a, dout1_a}, {1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44});
    end
    a_idle();
    a_step();
    n_checks++;
    if ({v0_a, dout0_a, v1_a, dout1_a} !== {1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44}) begin
      n_fail++; $display("FAIL hold_dout: got %h expected %h", {v0_a, dout0_a, v1_a, dout1_a}, {1'b0, 32'hAA22CC44, 1'b0, 32'hAA22CC44});
    end
  endtask

  task automatic test_collision;
    csb0_a = 1'b0; web0_a = 1'b0; addr0_a = 9'd7; din0_a = 32'hDEADBEEF; wmask0_a = 4'hF;
    csb1_a = 1'b0; addr1_a = 9'd7;
    a_step();
    n_checks++;
    if ({v1_a, col_a, dout1_a} !== {2'b11, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL bypass_collision: got %h expected %h", {v1_a, col_a, dout1_a}, {2'b11, 32'hDEADBEEF});
    end
    din0_a = 32'h0; wmask0_a = 4'h0;
    a_step();
    n_checks++;
    if ({v1_a, col_a, dout1_a} !== {2'b10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL zero_mask_no_collision: got %h expected %h", {v1_a, col_a, dout1_a}, {2'b10, 32'hDEADBEEF});
    end
    a_idle();
  endtask

  task automatic test_back_to_back;
    int bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      csb0_a = 1'b0; web0_a = 1'b1; addr0_a = 9'($urandom); csb1_a = 1'b0; addr1_a = 9'($urandom);
      a_step();
      if ({v0_a, dout0_a, v1_a, dout1_a} !== {1'b1, exp_d0, 1'b1, exp_d1}) bad++;
    end
    a_idle();
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL back_to_back: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_random;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      csb0_a = ($urandom_range(3) == 0); web0_a = 1'($urandom_range(1));
      wmask0_a = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      addr0_a = 9'($urandom_range(15)); din0_a = $urandom;
      csb1_a = ($urandom_range(3) == 0); addr1_a = 9'($urandom_range(15));
      a_step();
      n_checks++;
      if ({v0_a, dout0_a, v1_a, dout1_a, col_a} !== {exp_v0, exp_d0, exp_v1, exp_d1, exp_col}) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i,
          {v0_a, dout0_a, v1_a, dout1_a, col_a}, {exp_v0, exp_d0, exp_v1, exp_d1, exp_col});
      end
    end
    a_idle();
  endtask

  task automatic test_reset_midinit;
    int low;
    low = 0;
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy_a !== 1'b1) low++;
      tick();
    end
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    n_checks++;
    if (low != 0) begin
      n_fail++; $display("FAIL midinit_busy_low: got %0d cycles expected 0", low);
    end
    count_init("reinit");
    csb1_a = 1'b0; addr1_a = 9'd5;
    a_step();
    n_checks++;
    if ({v1_a, dout1_a} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL reinit_zeroed: got %h expected %h", {v1_a, dout1_a}, {1'b1, 32'h0});
    end
    a_idle();
  endtask

  task automatic test_wide_reset;
    n_checks++;
    if ({busy_b, v0_b, v1_b, col_b, dout0_b, dout1_b} !== 132'h0) begin
      n_fail++; $display("FAIL wide_reset: got %h expected %h", {busy_b, v0_b, v1_b, col_b, dout0_b, dout1_b}, 132'h0);
    end
    rst_b = 1'b0;
  endtask

  task automatic test_wide_mask;
    csb0_b = 1'b0; web0_b = 1'b0; addr0_b = 4'd3; din0_b = 64'h0; wmask0_b = 4'hF;
    tick();
    din0_b = '1; wmask0_b = 4'b1000;
    tick();
    web0_b = 1'b1; wmask0_b = 4'h0; csb1_b = 1'b0; addr1_b = 4'd3;
    tick();
    b_idle();
    n_checks++;
    if ({v0_b, v1_b} !== 2'b00) begin
      n_fail++; $display("FAIL wide_latency_early: got %b expected %b", {v0_b, v1_b}, 2'b00);
    end
    tick();
    n_checks++;
    if ({v0_b, dout0_b, v1_b, dout1_b} !== {1'b1, 64'hFFFF000000000000, 1'b1, 64'hFFFF000000000000}) begin
      n_fail++; $display("FAIL wide_mask_read: got %h expected %h", {v0_b, dout0_b, v1_b, dout1_b}, {1'b1, 64'hFFFF000000000000, 1'b1, 64'hFFFF000000000000});
    end
    tick();
    n_checks++;
    if ({v0_b, v1_b} !== 2'b00) begin
      n_fail++; $display("FAIL wide_valid_one_cycle: got %b expected %b", {v0_b, v1_b}, 2'b00);
    end
  endtask

  task automatic test_bypass_off;
    csb0_b = 1'b0; web0_b = 1'b0; addr0_b = 4'd9; din0_b = 64'h0; wmask0_b = 4'hF;
    tick();
    din0_b = '1; csb1_b = 1'b0; addr1_b = 4'd9;
    tick();
    b_idle();
    tick();
    n_checks++;
    if ({v1_b, col_b, dout1_b} !== {2'b11, 64'h0}) begin
      n_fail++; $display("FAIL nobypass_collision: got %h expected %h", {v1_b, col_b, dout1_b}, {2'b11, 64'h0});
    end
    tick();
    n_checks++;
    if ({v1_b, col_b} !== 2'b00) begin
      n_fail++; $display("FAIL nobypass_collision_pulse: got %b expected %b", {v1_b, col_b}, 2'b00);
    end
  endtask

  task automatic test_inflight_discard;
    csb1_b = 1'b0; addr1_b = 4'd9;
    tick();
    b_idle(); rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    n_checks++;
    if ({v1_b, busy_b, dout1_b} !== 66'h0) begin
      n_fail++; $display("FAIL inflight_discard: got %h expected %h", {v1_b, busy_b, dout1_b}, 66'h0);
    end
    csb1_b = 1'b0; addr1_b = 4'd3;
    tick();
    b_idle();
    tick();
    n_checks++;
    if ({v1_b, dout1_b} !== {1'b1, 64'hFFFF000000000000}) begin
      n_fail++; $display("FAIL array_kept_over_reset: got %h expected %h", {v1_b, dout1_b}, {1'b1, 64'hFFFF000000000000});
    end
  endtask

  initial begin
    rst_a = 1'b1; a_idle(); addr0_a = '0; addr1_a = '0; din0_a = '0;
    rst_b = 1'b1; b_idle(); addr0_b = '0; addr1_b = '0; din0_b = '0;
    test_reset();
    test_init_sweep();
    test_init_reads();
    test_mask_write();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_midinit();
    test_wide_reset();
    test_wide_mask();
    test_bypass_off();
    test_inflight_discard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ldpc_sram_1rw1r_param.md
LDPC_SRAM_1RW1R_PARAM -- requirements
Module: ldpc_sram_1rw1r_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter WMASK_GRAN, default 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN; DATA_WIDTH not a multiple of WMASK_GRAN is an elaboration error.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds one output pipeline register per read port.
REQ-005 SHALL have parameter BYPASS, default 1; 1 forwards a same-cycle port-0 write to a port-1 read of the same address.
REQ-006 SHALL have parameter INIT_ZERO, default 1; 1 zero-fills the array after reset.
REQ-007 Ports (name direction width meaning):
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- csb0  in  1  port-0 select, active low.
- web0  in  1  port-0 write enable, active low.
- wmask0  in  NUM_WMASKS  lane write enables, bit i covers din0[i*WMASK_GRAN +: WMASK_GRAN].
- addr0  in  ADDR_WIDTH  port-0 address.
- din0  in  DATA_WIDTH  port-0 write data.
- dout0  out  DATA_WIDTH  port-0 read data.
- dout0_valid  out  1  dout0 holds a new read result.
- csb1  in  1  port-1 (read-only) select, active low.
- addr1  in  ADDR_WIDTH  port-1 address.
- dout1  out  DATA_WIDTH  port-1 read data.
- dout1_valid  out  1  dout1 holds a new read result.
- collision  out  1  port-1 read hit the address port 0 wrote the same cycle.
- init_busy  out  1  zero-fill in progress; requests ignored.

Function
REQ-008 Controller FSM SHALL have states INIT and READY; rst forces INIT when INIT_ZERO=1, else READY.
REQ-009 In INIT, one word per cycle SHALL be zeroed, ascending from 0; after DEPTH-1 is written, next state is READY; init_busy=1 exactly DEPTH cycles.
REQ-010 In INIT, csb0/csb1 SHALL be ignored: no writes, no reads, valids held 0.
REQ-011 rst during INIT SHALL restart the sweep at address 0.
REQ-012 Port-0 write (READY, csb0=0, web0=0) SHALL update only lanes with wmask0[i]=1 at the sampling posedge; other lanes keep their value.
REQ-013 Port-0 write SHALL leave dout0 unchanged and dout0_valid=0 the following cycle.
REQ-014 Port-0 read (csb0=0, web0=1) and port-1 read (csb1=0) SHALL present data after L = 1+OUT_REG posedges, with the matching valid high for exactly one cycle.
REQ-015 Reads SHALL return array contents as they were before any write sampled in the same cycle, except REQ-016.
REQ-016 Port-1 read with addr1==addr0 during a port-0 write: BYPASS=1 returns the merged word (new masked lanes, old others); BYPASS=0 returns the old word.
REQ-017 collision SHALL assert for that case (any BYPASS), aligned with dout1_valid, one cycle.
REQ-018 Write with wmask0 all zero SHALL not alter the array and SHALL not assert collision.
REQ-019 dout0/dout1 SHALL hold the last read result when no new read completes.
REQ-020 Back-to-back reads every cycle SHALL sustain throughput of one per port per cycle; addresses wrap only within 0..DEPTH-1 (no out-of-range state).

Reset
REQ-021 On rst: dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision=0, pipeline registers cleared, init_busy=INIT_ZERO the next cycle.
REQ-022 Without INIT_ZERO, array contents SHALL be unaffected by rst.
REQ-023 Reads in flight at rst SHALL be discarded (no valid pulse after rst).

Verification
REQ-024 Reset, INIT_ZERO=1, DEPTH=512 -> init_busy high 512 cycles; then port-1 reads of addr 0, 511 return 0x00000000.
REQ-025 Write addr 5 din 0xAABBCCDD mask 4'b1111, then mask 4'b0101 din 0x11223344 -> read addr 5 returns 0xAA22CC44, valid at L=1 (OUT_REG=0) and L=2 (OUT_REG=1).
REQ-026 Port-0 write addr 7 din 0xDEADBEEF mask 4'b1111 with port-1 read addr 7 same cycle, old 0 -> BYPASS=1: dout1=0xDEADBEEF, collision=1; BYPASS=0: dout1=0, collision=1.
REQ-027 rst asserted at sweep address 100 -> sweep restarts at 0, init_busy stays high a further 512 cycles, no valid pulses.
REQ-028 DATA_WIDTH=64, WMASK_GRAN=16, ADDR_WIDTH=4 -> mask lanes 16 bits; write mask 4'b1000 din all-ones over zero -> read 0xFFFF000000000000.
